// File: rtl/wavelet_pkg.sv
// Shared definitions for the wavelet accelerator output drainer: register map,
// config bit positions and the drainer state encoding.
package wavelet_pkg;

  localparam logic [31:0] WAVELET_BASE_ADDRESS = 32'h1A100000;
  localparam logic [1:0]  CFG_REG_SEL          = 2'b00;
  localparam logic [1:0]  OUT_REG_SEL          = 2'b10;
  localparam int          CFG_AVAIL_BIT        = 7;

  // Index of the last byte fetched for each register (config needs byte 0 only)
  localparam logic [1:0]  CFG_LAST_BYTE        = 2'd0;
  localparam logic [1:0]  OUT_LAST_BYTE        = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    RD_CFG,
    GAP_CFG,
    RD_OUT,
    PUSH,
    GAP_OUT,
    DONE
  } drain_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/wavelet_bus_reader.sv
// Byte-serial little-endian reader: fetches 1..4 bytes from consecutive byte
// addresses. Optional watchdog enabled by WAVELET_DRAIN_TIMEOUT_EN.
module wavelet_bus_reader
  import wavelet_pkg::*;
#(
  parameter int DATA_BUS_WIDTH = 8,
  parameter int ADDR_BUS_WIDTH = 32
`ifdef WAVELET_DRAIN_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      go,
  input  logic [ADDR_BUS_WIDTH-1:0] base_addr,
  input  logic [1:0]                last_idx,
  output logic [ADDR_BUS_WIDTH-1:0] addr,
  output logic                      read_en,
  input  logic [DATA_BUS_WIDTH-1:0] data,
  input  logic                      data_ready,
  output logic [31:0]               word,
  output logic                      done
`ifdef WAVELET_DRAIN_TIMEOUT_EN
  ,
  output logic                      timeout
`endif
);

  logic [1:0]  byte_idx;
  logic [1:0]  last_q;
  logic [31:0] word_q;
  logic        byte_hit;

  assign byte_hit = read_en & data_ready;
  assign done     = byte_hit & (byte_idx == last_q);

  // Word includes the byte on the bus this cycle so the caller can take it on done
  always_comb begin
    word = word_q;
    word[8*byte_idx +: 8] = data[7:0];
  end

`ifdef WAVELET_DRAIN_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  assign timeout = read_en & ~data_ready & (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst || go || byte_hit || !read_en) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      read_en  <= 1'b0;
      addr     <= '0;
      byte_idx <= 2'd0;
      last_q   <= 2'd0;
      word_q   <= 32'd0;
    end else if (go) begin
      read_en  <= 1'b1;
      addr     <= base_addr;
      byte_idx <= 2'd0;
      last_q   <= last_idx;
      word_q   <= 32'd0;
    end else if (byte_hit) begin
      word_q <= word;
      if (done) begin
        read_en  <= 1'b0;
        addr     <= '0;
        byte_idx <= 2'd0;
      end else begin
        byte_idx  <= byte_idx + 2'd1;
        addr[1:0] <= byte_idx + 2'd1;
      end
`ifdef WAVELET_DRAIN_TIMEOUT_EN
    end else if (timeout) begin
      read_en  <= 1'b0;
      addr     <= '0;
      byte_idx <= 2'd0;
`endif
    end
  end

endmodule

// File: rtl/wavelet_output_drainer.sv
// Polls the accelerator config register and drains 32-bit output words onto a
// valid/ready stream. WAVELET_DRAIN_TIMEOUT_EN adds a data_ready watchdog.
module wavelet_output_drainer
  import wavelet_pkg::*;
#(
  parameter int                      DATA_BUS_WIDTH    = 8,
  parameter int                      ADDR_BUS_WIDTH    = 32,
  parameter logic [ADDR_BUS_WIDTH-1:0] BASE_ADDRESS    = WAVELET_BASE_ADDRESS,
  parameter logic [1:0]              CONFIG_REG_OFFSET = CFG_REG_SEL,
  parameter logic [1:0]              OUTPUT_REG_OFFSET = OUT_REG_SEL,
  parameter int                      POLL_GAP          = 4,
  parameter int                      TIMEOUT_CYCLES    = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic [ADDR_BUS_WIDTH-1:0] bus_addr_out,
  output logic                      bus_read_en_out,
  input  logic [DATA_BUS_WIDTH-1:0] bus_data_in,
  input  logic                      bus_data_ready_in,
  output logic [31:0]               out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      done,
  output logic [15:0]               out_count
`ifdef WAVELET_DRAIN_TIMEOUT_EN
  ,
  output logic                      timeout_err
`endif
);

  localparam logic [15:0] GAP_LOAD = 16'(POLL_GAP - 1);

  drain_state_t              state;
  logic [15:0]               gap_cnt;
  logic                      cfg_avail;
  logic                      rd_go;
  logic [1:0]                rd_sel;
  logic [1:0]                rd_last;
  logic [ADDR_BUS_WIDTH-1:0] rd_base;
  logic [31:0]               rd_word;
  logic                      rd_done;
  logic                      rd_timeout;

  assign rd_base = {BASE_ADDRESS[ADDR_BUS_WIDTH-1:4], rd_sel, 2'b00};

  // Reads are launched on the transition edge so read_en is high in the first read cycle
  always_comb begin
    rd_go   = 1'b0;
    rd_sel  = CONFIG_REG_OFFSET;
    rd_last = CFG_LAST_BYTE;
    case (state)
      IDLE:    rd_go = start;
      GAP_OUT: rd_go = (gap_cnt == 16'd0);
      GAP_CFG: begin
        if (gap_cnt == 16'd0 && cfg_avail) begin
          rd_go   = 1'b1;
          rd_sel  = OUTPUT_REG_OFFSET;
          rd_last = OUT_LAST_BYTE;
        end
      end
      default: ;
    endcase
  end

  wavelet_bus_reader #(
    .DATA_BUS_WIDTH (DATA_BUS_WIDTH),
    .ADDR_BUS_WIDTH (ADDR_BUS_WIDTH)
`ifdef WAVELET_DRAIN_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`endif
  ) u_reader (
    .clk        (clk),
    .rst        (rst),
    .go         (rd_go),
    .base_addr  (rd_base),
    .last_idx   (rd_last),
    .addr       (bus_addr_out),
    .read_en    (bus_read_en_out),
    .data       (bus_data_in),
    .data_ready (bus_data_ready_in),
    .word       (rd_word),
    .done       (rd_done)
`ifdef WAVELET_DRAIN_TIMEOUT_EN
    ,
    .timeout    (rd_timeout)
`endif
  );

`ifdef WAVELET_DRAIN_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      timeout_err <= 1'b0;
    end else if (state == IDLE && start) begin
      timeout_err <= 1'b0;
    end else if (rd_timeout) begin
      timeout_err <= 1'b1;
    end
  end
`else
  assign rd_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      gap_cnt   <= 16'd0;
      cfg_avail <= 1'b0;
      out_data  <= 32'd0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_count <= 16'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RD_CFG;
            busy      <= 1'b1;
            out_count <= 16'd0;
          end
        end
        RD_CFG: begin
          if (rd_timeout) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (rd_done) begin
            cfg_avail <= rd_word[CFG_AVAIL_BIT];
            gap_cnt   <= GAP_LOAD;
            state     <= GAP_CFG;
          end
        end
        GAP_CFG: begin
          if (gap_cnt == 16'd0) begin
            if (cfg_avail) begin
              state <= RD_OUT;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end
        RD_OUT: begin
          if (rd_timeout) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (rd_done) begin
            out_data  <= rd_word;
            out_valid <= 1'b1;
            state     <= PUSH;
          end
        end
        PUSH: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_count <= sat_inc16(out_count);
            gap_cnt   <= GAP_LOAD;
            state     <= GAP_OUT;
          end
        end
        GAP_OUT: begin
          if (gap_cnt == 16'd0) begin
            state <= RD_CFG;
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wavelet_output_drainer.sv
// Scoreboard bench for wavelet_output_drainer with a byte-wide accelerator model.
module tb_wavelet_output_drainer;

  localparam logic [31:0] BASE = 32'h1A100000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] bus_addr_out;
  logic        bus_read_en_out;
  logic [7:0]  bus_data_in;
  logic        bus_data_ready_in;
  logic [31:0] out_data;
  logic        out_valid;
  logic        busy;
  logic        done;
  logic [15:0] out_count;
`ifdef WAVELET_DRAIN_TIMEOUT_EN
  logic        timeout_err;
`endif

  always #5 clk = ~clk;

  wavelet_output_drainer #(
    .POLL_GAP       (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .bus_addr_out      (bus_addr_out),
    .bus_read_en_out   (bus_read_en_out),
    .bus_data_in       (bus_data_in),
    .bus_data_ready_in (bus_data_ready_in),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .busy              (busy),
    .done              (done),
    .out_count         (out_count)
`ifdef WAVELET_DRAIN_TIMEOUT_EN
    ,
    .timeout_err       (timeout_err)
`endif
  );

  // Accelerator model configuration (written by stimulus only)
  logic [31:0] words [8];
  int          n_words = 0;
  int          stall_byte = -1;
  int          stall_len = 0;
  bit          never_ready = 1'b0;
  int          clear_req = 0;

  // Accelerator model state (written by the model process only)
  int widx = 0, wait_cnt = 0, clear_seen = 0;
  bit adv_pending = 1'b0;
  int cfg_reads = 0, out_reads = 0, done_pulses = 0, stall_cycles = 0, bad_stall = 0, bad_addr = 0;

  logic is_cfg, is_out;
  always_comb begin
    is_cfg = (bus_addr_out[3:2] == 2'b00);
    is_out = (bus_addr_out[3:2] == 2'b10);
    bus_data_ready_in = 1'b0;
    if (bus_read_en_out && !never_ready) begin
      if (is_out && int'(bus_addr_out[1:0]) == stall_byte) bus_data_ready_in = (wait_cnt >= stall_len);
      else bus_data_ready_in = 1'b1;
    end
    bus_data_in = 8'h00;
    if (is_cfg) bus_data_in = (widx < n_words) ? 8'hC3 : 8'h7F;
    else if (is_out && widx < 8) begin
      case (bus_addr_out[1:0])
        2'd0: bus_data_in = words[widx][7:0];
        2'd1: bus_data_in = words[widx][15:8];
        2'd2: bus_data_in = words[widx][23:16];
        default: bus_data_in = words[widx][31:24];
      endcase
    end
  end

  always @(negedge clk) begin
    if (clear_req != clear_seen) begin
      clear_seen = clear_req;
      widx = 0; wait_cnt = 0; adv_pending = 1'b0;
      cfg_reads = 0; out_reads = 0; done_pulses = 0; stall_cycles = 0; bad_stall = 0;
    end else begin
      if (done) done_pulses++;
      if (bus_read_en_out) begin
        if (bus_addr_out[31:4] != BASE[31:4] || !(is_cfg || is_out)) bad_addr++;
        if (is_cfg && bus_addr_out[1:0] != 2'd0) bad_addr++;
      end else if (bus_addr_out != 32'd0) begin
        bad_addr++;
      end
      if (bus_read_en_out && bus_data_ready_in) begin
        if (is_cfg) cfg_reads++;
        if (is_out) out_reads++;
        if (is_out && bus_addr_out[1:0] == 2'd3) adv_pending = 1'b1;
      end
      if (bus_read_en_out && !bus_data_ready_in && is_out) begin
        stall_cycles++;
        if (bus_addr_out != (BASE | 32'h0000_000A)) bad_stall++;
      end
      if (!bus_read_en_out && adv_pending) begin
        widx++;
        adv_pending = 1'b0;
      end
      if (bus_read_en_out && !bus_data_ready_in) wait_cnt++;
      else wait_cnt = 0;
    end
  end

  // Scoreboard monitor
  logic [31:0] exp_q [$];
  int sb_checks = 0, sb_pass = 0;
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      sb_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected_word: got %h required none", out_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (out_data === e) sb_pass++;
        else $display("FAIL sb_word: got %h required %h", out_data, e);
      end
    end
  end

  int n_checks = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Counts cycles after the start-sampling edge until done is seen
  task automatic run_until_done(input int max, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < max);
  endtask

  task automatic load_model(input int n);
    n_words = n;
    clear_req++;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_addr"},  bus_addr_out, 32'd0);
    check({tag, "_rden"},  {31'd0, bus_read_en_out}, 32'd0);
    check({tag, "_data"},  out_data, 32'd0);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy}, 32'd0);
    check({tag, "_done"},  {31'd0, done}, 32'd0);
    check({tag, "_count"}, {16'd0, out_count}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got hang required finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int unstable;
    logic [31:0] held;

    // Reset state
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    rst = 1'b1;

    // No output available: single config read, then done
    load_model(0);
    pulse_start();
    run_until_done(60, cyc);
    check("empty_done_seen", {31'd0, done}, 32'd1);
    check("empty_latency", cyc, 6);
    check("empty_count", {16'd0, out_count}, 32'd0);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("empty_busy_after", {31'd0, busy}, 32'd0);
    check("empty_start_in_done_ignored", {31'd0, bus_read_en_out}, 32'd0);
    check("empty_cfg_reads", cfg_reads, 1);
    check("empty_out_reads", out_reads, 0);

    // Three words drained with immediate ready
    words[0] = 32'h12345678; words[1] = 32'hDEADBEEF; words[2] = 32'h00000001;
    load_model(3);
    exp_q.push_back(32'h12345678); exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'h00000001);
    out_ready = 1'b1;
    pulse_start();
    run_until_done(300, cyc);
    check("three_latency", cyc, 48);
    check("three_count", {16'd0, out_count}, 32'd3);
    @(negedge clk);
    check("three_done_pulses", done_pulses, 1);
    check("three_queue_empty", exp_q.size(), 0);
    check("three_out_reads", out_reads, 12);

    // Backpressure in PUSH and a stalled byte 2
    words[0] = 32'hDEADBEEF;
    stall_byte = 2; stall_len = 5;
    load_model(1);
    exp_q.push_back(32'hDEADBEEF);
    out_ready = 1'b0;
    pulse_start();
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("bp_valid_seen", {31'd0, out_valid}, 32'd1);
    held = out_data;
    unstable = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== held || bus_read_en_out !== 1'b0) unstable++;
    end
    check("bp_held_word", held, 32'hDEADBEEF);
    check("bp_stable", unstable, 0);
    check("stall_cycles", stall_cycles, 5);
    check("stall_addr_hold", bad_stall, 0);
    out_ready = 1'b1;
    run_until_done(100, cyc);
    check("bp_done_seen", {31'd0, done}, 32'd1);
    check("bp_count", {16'd0, out_count}, 32'd1);
    stall_byte = -1; stall_len = 0;

    // Reset during output byte 1, then a clean rerun
    words[0] = 32'hCAFEF00D; words[1] = 32'h0BADC0DE;
    load_model(2);
    pulse_start();
    cyc = 0;
    while (!(bus_read_en_out && bus_addr_out == (BASE | 32'h9)) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_reached_byte1", bus_addr_out, BASE | 32'h9);
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("midrst");
    rst = 1'b1;
    load_model(2);
    repeat (15) @(negedge clk);
    check("midrst_idle_busy", {31'd0, busy}, 32'd0);
    check("midrst_no_reads", cfg_reads + out_reads, 0);
    exp_q.push_back(32'hCAFEF00D); exp_q.push_back(32'h0BADC0DE);
    pulse_start();
    run_until_done(300, cyc);
    check("rerun_latency", cyc, 34);
    check("rerun_count", {16'd0, out_count}, 32'd2);

`ifdef WAVELET_DRAIN_TIMEOUT_EN
    // data_ready never arrives
    never_ready = 1'b1;
    load_model(1);
    pulse_start();
    run_until_done(100, cyc);
    check("to_latency", cyc, 17);
    check("to_err", {31'd0, timeout_err}, 32'd1);
    @(negedge clk);
    check("to_err_held", {31'd0, timeout_err}, 32'd1);
    check("to_busy_after", {31'd0, busy}, 32'd0);
    never_ready = 1'b0;
    load_model(0);
    pulse_start();
    @(negedge clk);
    check("to_err_cleared", {31'd0, timeout_err}, 32'd0);
    run_until_done(60, cyc);
`endif

    repeat (3) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    check("bus_addr_legal", bad_addr, 0);

    $display("%0d/%0d checks passed", n_pass + sb_pass, n_checks + sb_checks);
    $finish;
  end

endmodule
